// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit:
// FSM states, opcode classes, ALU/PC control codes and error codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_WAIT_INS = 4'd2,
    ST_DECODE   = 4'd3,
    ST_EXEC     = 4'd4,
    ST_WAIT_ALU = 4'd5,
    ST_WB       = 4'd6,
    ST_PC_UPD   = 4'd7,
    ST_HALT     = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_LDI  = 3'd1,
    CLS_JMP  = 3'd2,
    CLS_JZ   = 3'd3,
    CLS_HALT = 3'd4,
    CLS_ALU  = 3'd5,
    CLS_ILL  = 3'd6
  } op_class_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_JZ   = 4'h3;
  localparam logic [3:0] OP_HALT = 4'h4;

  localparam logic [2:0] ALU_PASS_B = 3'b000;

  localparam logic [1:0] PC_INC   = 2'b00;
  localparam logic [1:0] PC_LOAD  = 2'b01;
  localparam logic [1:0] PC_CLEAR = 2'b10;
  localparam logic [1:0] PC_HOLD  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Any nonzero bit above the low nibble makes the opcode illegal.
  function automatic op_class_e classify_op(input logic [3:0] op_lo, input logic hi_zero);
    op_class_e cls;
    if (!hi_zero) begin
      cls = CLS_ILL;
    end else if (op_lo[3]) begin
      cls = CLS_ALU;
    end else begin
      case (op_lo)
        OP_NOP:  cls = CLS_NOP;
        OP_LDI:  cls = CLS_LDI;
        OP_JMP:  cls = CLS_JMP;
        OP_JZ:   cls = CLS_JZ;
        OP_HALT: cls = CLS_HALT;
        default: cls = CLS_ILL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_ir.sv
// Instruction register with load enable and synchronous reset; splits the
// held word into opcode, rd, rs and offset fields.
module ctrl_ir #(
  parameter int DWIDTH = 16,
  parameter int OPW    = 4,
  parameter int RDW    = 2,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DWIDTH-1:0] ins_i,
  output logic [DWIDTH-1:0] ir_o,
  output logic [OPW-1:0]    opcode_o,
  output logic [RDW-1:0]    rd_o,
  output logic [RDW-1:0]    rs_o,
  output logic [AWIDTH-1:0] offset_o
);

  logic [DWIDTH-1:0] ir_d;
  logic [DWIDTH-1:0] ir_q;

  always_comb begin
    ir_d = ir_q;
    if (load_i) begin
      ir_d = ins_i;
    end else begin
      ir_d = ir_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_q <= {DWIDTH{1'b0}};
    end else begin
      ir_q <= ir_d;
    end
  end

  assign ir_o     = ir_q;
  assign opcode_o = ir_q[DWIDTH-1 -: OPW];
  assign rd_o     = ir_q[DWIDTH-OPW-1 -: RDW];
  assign rs_o     = ir_q[DWIDTH-OPW-RDW-1 -: RDW];
  assign offset_o = ir_q[AWIDTH-1:0];

endmodule

// File: rtl/control_unit_p.sv
// Multi-cycle instruction sequencer: fetch/decode/execute FSM with memory and
// ALU wait handshakes, a shared watchdog, zero-flag branching and sticky errors.
module control_unit_p
  import ctrl_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int OPW     = 4,
  parameter int NREG    = 4,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DWIDTH-1:0] ins,
  input  logic              ins_valid,
  input  logic              alu_done,
  input  logic              alu_zero,
  output logic              fetch_req,
  output logic              group_pulse,
  output logic              pc_pulse,
  output logic [1:0]        pc_ctrl,
  output logic [NREG-1:0]   reg_en,
  output logic [2:0]        alu_func,
  output logic              alu_in_sel,
  output logic [AWIDTH-1:0] offset_addr,
  output logic [DWIDTH-1:0] ir_out,
  output logic              halted,
  output logic [1:0]        err_code
);

  localparam int RDW = $clog2(NREG);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT - 1);
  localparam logic [NREG-1:0] REG_ONE   = NREG'(1);

  state_e            state_q, state_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic              zero_q, zero_d;
  logic [1:0]        err_q, err_d;

  logic              ir_load_s;
  logic [DWIDTH-1:0] ir_s;
  logic [OPW-1:0]    opcode_s;
  logic [RDW-1:0]    rd_s;
  logic [RDW-1:0]    rs_unused_s;
  logic [AWIDTH-1:0] offset_s;
  logic              op_hi_zero_s;
  op_class_e         op_cls_s;
  logic              waiting_s;
  logic              wdog_last_s;

  ctrl_ir #(
    .DWIDTH (DWIDTH),
    .OPW    (OPW),
    .RDW    (RDW),
    .AWIDTH (AWIDTH)
  ) u_ir (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (ir_load_s),
    .ins_i    (ins),
    .ir_o     (ir_s),
    .opcode_o (opcode_s),
    .rd_o     (rd_s),
    .rs_o     (rs_unused_s),
    .offset_o (offset_s)
  );

  assign ir_load_s    = (state_q == ST_WAIT_INS) && ins_valid;
  assign op_hi_zero_s = ((opcode_s >> 3'd4) == {OPW{1'b0}});
  assign op_cls_s     = classify_op(opcode_s[3:0], op_hi_zero_s);
  assign waiting_s    = (state_q == ST_WAIT_INS) || (state_q == ST_WAIT_ALU);
  assign wdog_last_s  = (wdog_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A handshake arriving on the last permitted wait cycle beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_FETCH;
        else    state_d = ST_IDLE;
      end
      ST_FETCH: state_d = ST_WAIT_INS;
      ST_WAIT_INS: begin
        if (ins_valid)        state_d = ST_DECODE;
        else if (wdog_last_s) state_d = ST_HALT;
        else                  state_d = ST_WAIT_INS;
      end
      ST_DECODE: begin
        case (op_cls_s)
          CLS_NOP, CLS_JMP, CLS_JZ: state_d = ST_PC_UPD;
          CLS_LDI, CLS_ALU:         state_d = ST_EXEC;
          default:                  state_d = ST_HALT;
        endcase
      end
      ST_EXEC: state_d = ST_WAIT_ALU;
      ST_WAIT_ALU: begin
        if (alu_done)         state_d = ST_WB;
        else if (wdog_last_s) state_d = ST_HALT;
        else                  state_d = ST_WAIT_ALU;
      end
      ST_WB: state_d = ST_PC_UPD;
      ST_PC_UPD: begin
        if (en) state_d = ST_FETCH;
        else    state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wdog_d = {WDW{1'b0}};
    zero_d = zero_q;
    err_d  = err_q;
    if (waiting_s) begin
      wdog_d = wdog_q + {{(WDW-1){1'b0}}, 1'b1};
    end else begin
      wdog_d = {WDW{1'b0}};
    end
    if ((state_q == ST_WAIT_ALU) && alu_done) begin
      zero_d = alu_zero;
    end else begin
      zero_d = zero_q;
    end
    // Only the first error is recorded.
    if (err_q != ERR_NONE) begin
      err_d = err_q;
    end else if ((state_q == ST_DECODE) && (op_cls_s == CLS_ILL)) begin
      err_d = ERR_ILLEGAL;
    end else if ((state_q == ST_WAIT_INS) && !ins_valid && wdog_last_s) begin
      err_d = ERR_TIMEOUT;
    end else if ((state_q == ST_WAIT_ALU) && !alu_done && wdog_last_s) begin
      err_d = ERR_TIMEOUT;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= {WDW{1'b0}};
      zero_q <= 1'b0;
      err_q  <= ERR_NONE;
    end else begin
      wdog_q <= wdog_d;
      zero_q <= zero_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    fetch_req   = (state_q == ST_FETCH);
    group_pulse = (state_q == ST_EXEC);
    pc_pulse    = (state_q == ST_PC_UPD);
    halted      = (state_q == ST_HALT);
    reg_en      = {NREG{1'b0}};
    if (state_q == ST_WB) begin
      reg_en = REG_ONE << rd_s;
    end else begin
      reg_en = {NREG{1'b0}};
    end
    alu_func   = ALU_PASS_B;
    alu_in_sel = 1'b0;
    pc_ctrl    = PC_INC;
    case (op_cls_s)
      CLS_ALU: alu_func   = opcode_s[2:0];
      CLS_LDI: alu_in_sel = 1'b1;
      CLS_JMP: pc_ctrl    = PC_LOAD;
      CLS_JZ: begin
        if (zero_q) pc_ctrl = PC_LOAD;
        else        pc_ctrl = PC_INC;
      end
      default: begin
        alu_func   = ALU_PASS_B;
        alu_in_sel = 1'b0;
        pc_ctrl    = PC_INC;
      end
    endcase
  end

  assign offset_addr = offset_s;
  assign ir_out      = ir_s;
  assign err_code    = err_q;

endmodule
